// File: rtl/udp_tx_packetizer.sv
// Store-and-forward byte-stream to UDP datagram packetizer: buffers payload, then issues header and replays the buffer.
// Header 1 cycle after close, payload 2 cycles after header handshake; input stalls (tready=0) while HDR/SEND.
module udp_tx_packetizer #(
  parameter int          MAX_PAYLOAD    = 1024,
  parameter int          TIMEOUT_CYCLES = 125000,
  parameter logic [15:0] SRC_PORT       = 16'd1234,
  parameter logic [15:0] DEST_PORT      = 16'd1234,
  parameter logic [7:0]  TTL            = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [31:0] local_ip,
  input  logic [31:0] dest_ip,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_udp_ip_dscp,
  output logic [1:0]  m_udp_ip_ecn,
  output logic [7:0]  m_udp_ip_ttl,
  output logic [31:0] m_udp_ip_source_ip,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
  output logic        busy,
  output logic [31:0] datagram_count
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  typedef enum logic [1:0] {FILL, HDR, SEND} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [0:MAX_PAYLOAD-1];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] cnt_new;
  logic [31:0]   timer;
  logic [31:0]   src_ip_q;
  logic [31:0]   dst_ip_q;
  logic [15:0]   len_q;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic          pay_vld;
  logic          pay_last;
  logic [7:0]    pay_dat;
  logic [31:0]   dg_cnt;
  logic          accept;
  logic          timeout_hit;
  logic          close;

  assign s_axis_tready = rst && (state == FILL) && (cnt < CW'(MAX_PAYLOAD));
  assign accept        = s_axis_tready && s_axis_tvalid;
  assign cnt_inc       = cnt + CW'(1);
  assign cnt_new       = accept ? cnt_inc : cnt;
  // An accepted byte always beats the timer: the timeout term only applies on idle cycles.
  assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (state == FILL) && (cnt != '0) &&
                         (timer == 32'(TIMEOUT_CYCLES));
  assign close         = accept ? (s_axis_tlast || (cnt_inc == CW'(MAX_PAYLOAD))) : timeout_hit;

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = rd_ptr;
    case (state)
      FILL: if (close) state_nxt = HDR;
      HDR:  if (m_udp_hdr_ready) state_nxt = SEND;
      SEND: begin
        // First SEND cycle primes the synchronous RAM read; afterwards each handshake fetches the next byte.
        if (!pay_vld) begin
          rd_en   = 1'b1;
          rd_addr = '0;
        end else if (m_udp_payload_axis_tready) begin
          if (pay_last) state_nxt = FILL;
          else          rd_en     = 1'b1;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FILL;
      cnt      <= '0;
      timer    <= '0;
      src_ip_q <= '0;
      dst_ip_q <= '0;
      len_q    <= '0;
      rd_ptr   <= '0;
      pay_vld  <= 1'b0;
      pay_last <= 1'b0;
      dg_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt   <= cnt_inc;
        timer <= '0;
      end else if ((TIMEOUT_CYCLES != 0) && (state == FILL) && (cnt != '0)) begin
        timer <= timer + 32'd1;
      end
      if (close) begin
        src_ip_q <= local_ip;
        dst_ip_q <= dest_ip;
        len_q    <= 16'(cnt_new) + 16'd8;
        timer    <= '0;
      end
      if (rd_en) begin
        pay_vld  <= 1'b1;
        pay_last <= (CW'(rd_addr) == (cnt - CW'(1)));
        rd_ptr   <= rd_addr + AW'(1);
      end
      if (pay_vld && m_udp_payload_axis_tready && pay_last) begin
        pay_vld  <= 1'b0;
        pay_last <= 1'b0;
        cnt      <= '0;
        timer    <= '0;
        dg_cnt   <= dg_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[cnt[AW-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst)       pay_dat <= '0;
    else if (rd_en) pay_dat <= mem[rd_addr];
  end

  assign m_udp_hdr_valid           = (state == HDR);
  assign m_udp_ip_dscp             = 6'd0;
  assign m_udp_ip_ecn              = 2'd0;
  assign m_udp_ip_ttl              = TTL;
  assign m_udp_ip_source_ip        = src_ip_q;
  assign m_udp_ip_dest_ip          = dst_ip_q;
  assign m_udp_source_port         = SRC_PORT;
  assign m_udp_dest_port           = DEST_PORT;
  assign m_udp_length              = len_q;
  assign m_udp_checksum            = 16'd0;
  assign m_udp_payload_axis_tdata  = pay_dat;
  assign m_udp_payload_axis_tvalid = pay_vld;
  assign m_udp_payload_axis_tlast  = pay_last;
  assign m_udp_payload_axis_tuser  = 1'b0;
  assign busy                      = (state != FILL);
  assign datagram_count            = dg_cnt;

endmodule
